// File: rtl/lfsr_period_checker.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_period_checker
//  Description : Controller and consumer for one attached LFSR. Loads a seed,
//                steps the LFSR until the seed state reappears and reports the
//                measured period, plus maximal-length, all-zero lock-up and
//                runaway (no return within 2^WIDTH steps) flags.
//                Optional macro LFSR_CHK_BALANCE_EN enables the ones_count
//                balance counter; without it ones_count is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_period_checker #(
    parameter int WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] lfsr_out,
    output logic [WIDTH-1:0] lfsr_seed,
    output logic             lfsr_load,
    output logic             lfsr_enable,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   period,
    output logic             maximal,
    output logic             stuck,
    output logic             timeout,
    output logic [WIDTH-1:0] ones_count
);

    // Step budget: a sequence that has not returned after 2^WIDTH steps never will.
    localparam logic [WIDTH:0] c_full  = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] c_max   = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] c_one   = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PRIME = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH:0]   r_count;
    logic [WIDTH:0]   r_period;
    logic             r_maximal;
    logic             r_stuck;
    logic             r_timeout;
    logic             w_out_zero;
    logic             w_run_match;
    logic             w_run_cap;
    logic             w_run_end;
    logic             w_accept;

    // Termination conditions of a RUN cycle, in priority order match > zero > cap.
    assign w_out_zero  = (lfsr_out == '0);
    assign w_run_match = (r_count != '0) && (lfsr_out == r_ref);
    assign w_run_cap   = (r_count == c_full);
    assign w_run_end   = w_run_match | w_out_zero | w_run_cap;
    assign w_accept    = (r_state == ST_IDLE) && start;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        w_next      = r_state;
        lfsr_load   = 1'b0;
        lfsr_enable = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                lfsr_load = 1'b1;
                busy      = 1'b1;
                w_next    = ST_PRIME;
            end
            ST_PRIME: begin
                busy   = 1'b1;
                w_next = w_out_zero ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                lfsr_enable = 1'b1;
                busy        = 1'b1;
                if (w_run_end) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Seed capture, step counting and result/flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_seed    <= '0;
            r_ref     <= '0;
            r_count   <= '0;
            r_period  <= '0;
            r_maximal <= 1'b0;
            r_stuck   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_seed    <= seed;
                        r_period  <= '0;
                        r_maximal <= 1'b0;
                        r_stuck   <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                ST_PRIME: begin
                    r_ref   <= lfsr_out;
                    r_count <= '0;
                    if (w_out_zero) begin
                        r_stuck  <= 1'b1;
                        r_period <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_run_match) begin
                        r_period  <= r_count;
                        r_maximal <= (r_count == c_max);
                    end else if (w_out_zero) begin
                        r_stuck  <= 1'b1;
                        r_period <= r_count;
                    end else if (w_run_cap) begin
                        r_timeout <= 1'b1;
                        r_period  <= r_count;
                    end else begin
                        r_count <= r_count + c_one;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign lfsr_seed = r_seed;
    assign period    = r_period;
    assign maximal   = r_maximal;
    assign stuck     = r_stuck;
    assign timeout   = r_timeout;

`ifdef LFSR_CHK_BALANCE_EN
    localparam logic [WIDTH-1:0] c_ones_one = {{(WIDTH-1){1'b0}}, 1'b1};
    logic [WIDTH-1:0] r_ones;

    // Count odd states visited before the run terminates, saturating at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ones <= '0;
        end else if (w_accept) begin
            r_ones <= '0;
        end else if ((r_state == ST_RUN) && !w_run_end && lfsr_out[0] && (r_ones != '1)) begin
            r_ones <= r_ones + c_ones_one;
        end
    end

    assign ones_count = r_ones;
`else
    assign ones_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_period_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_period_checker
//  Description : Self-checking bench for lfsr_period_checker at WIDTH 3, 4, 9
//                with behavioural Fibonacci LFSRs and a runaway sequence model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_period_checker;

`ifdef LFSR_CHK_BALANCE_EN
    localparam int c_bal = 1;
`else
    localparam int c_bal = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Free-running clock.
    always #5 clk = ~clk;

    // ---------------- WIDTH=3 instance ----------------
    logic       start3 = 1'b0;
    logic [2:0] seed3  = '0;
    logic [2:0] out3, lseed3, ones3;
    logic       load3, en3, busy3, done3, max3, stk3, to3;
    logic [3:0] per3;
    logic [2:0] q3  = '0;
    logic [2:0] rq3 = '0;
    logic       runaway = 1'b0;

    // Maximal 3-bit Fibonacci LFSR: 001,010,101,011,111,110,100.
    always @(posedge clk) begin
        if (load3)    q3 <= lseed3;
        else if (en3) q3 <= {q3[1:0], q3[2] ^ q3[1]};
    end

    // Runaway model: seed,2,3,4,5,4,5,... never returns to seed 1.
    always @(posedge clk) begin
        if (load3)    rq3 <= lseed3;
        else if (en3) rq3 <= (rq3 == 3'd5) ? 3'd4 : rq3 + 3'd1;
    end

    assign out3 = runaway ? rq3 : q3;

    lfsr_period_checker #(.WIDTH(3)) u_dut3 (
        .clock(clk), .reset(rst), .start(start3), .seed(seed3), .lfsr_out(out3),
        .lfsr_seed(lseed3), .lfsr_load(load3), .lfsr_enable(en3), .busy(busy3),
        .done(done3), .period(per3), .maximal(max3), .stuck(stk3), .timeout(to3),
        .ones_count(ones3)
    );

    // ---------------- WIDTH=4 instance ----------------
    logic       start4 = 1'b0;
    logic [3:0] seed4  = '0;
    logic [3:0] lseed4, ones4;
    logic       load4, en4, busy4, done4, max4, stk4, to4;
    logic [4:0] per4;
    logic [3:0] q4 = '0;

    // Maximal 4-bit Fibonacci LFSR (x^4+x^3+1).
    always @(posedge clk) begin
        if (load4)    q4 <= lseed4;
        else if (en4) q4 <= {q4[2:0], q4[3] ^ q4[2]};
    end

    lfsr_period_checker #(.WIDTH(4)) u_dut4 (
        .clock(clk), .reset(rst), .start(start4), .seed(seed4), .lfsr_out(q4),
        .lfsr_seed(lseed4), .lfsr_load(load4), .lfsr_enable(en4), .busy(busy4),
        .done(done4), .period(per4), .maximal(max4), .stuck(stk4), .timeout(to4),
        .ones_count(ones4)
    );

    // ---------------- WIDTH=9 instance ----------------
    logic       start9 = 1'b0;
    logic [8:0] seed9  = '0;
    logic [8:0] lseed9, ones9;
    logic       load9, en9, busy9, done9, max9, stk9, to9;
    logic [9:0] per9;
    logic [8:0] q9 = '0;

    // Maximal 9-bit Fibonacci LFSR (taps 9,5).
    always @(posedge clk) begin
        if (load9)    q9 <= lseed9;
        else if (en9) q9 <= {q9[7:0], q9[8] ^ q9[4]};
    end

    lfsr_period_checker #(.WIDTH(9)) u_dut9 (
        .clock(clk), .reset(rst), .start(start9), .seed(seed9), .lfsr_out(q9),
        .lfsr_seed(lseed9), .lfsr_load(load9), .lfsr_enable(en9), .busy(busy9),
        .done(done9), .period(per9), .maximal(max9), .stuck(stk9), .timeout(to9),
        .ones_count(ones9)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] seed;
        bit         runaway;
        int         period;
        bit         maximal;
        bit         stuck;
        bit         timeout;
        int         ones;
        int         done_cyc;
        int         en_cycles;
    } vec_t;

    vec_t vecs[5];
    int   k, loads, ens;
    bit   got;

    initial begin
        // seed, runaway, period, maximal, stuck, timeout, ones, done cycle, enable cycles
        vecs[0] = '{3'b001, 1'b0, 7, 1'b1, 1'b0, 1'b0, 4, 11, 8};
        vecs[1] = '{3'b110, 1'b0, 7, 1'b1, 1'b0, 1'b0, 4, 11, 8};
        vecs[2] = '{3'b000, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0,  3, 0};
        vecs[3] = '{3'b001, 1'b1, 8, 1'b0, 1'b0, 1'b1, 4, 12, 9};
        vecs[4] = '{3'b101, 1'b0, 7, 1'b1, 1'b0, 1'b0, 4, 11, 8};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy3, 0);
        check("rst_done", done3, 0);
        check("rst_load", load3, 0);
        check("rst_enable", en3, 0);
        check("rst_seed", lseed3, 0);
        check("rst_period", per3, 0);
        check("rst_flags", {max3, stk3, to3}, 0);
        check("rst_ones", ones3, 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven WIDTH=3 runs; vectors 0 and 1 are back-to-back.
        for (int i = 0; i < 5; i++) begin
            runaway = vecs[i].runaway;
            start3  = 1'b1;
            seed3   = vecs[i].seed;
            @(posedge clk);
            #1 start3 = 1'b0;
            seed3 = 3'b111;
            k = 0; loads = 0; ens = 0; got = 1'b0;
            while (k < 40 && !got) begin
                @(negedge clk);
                k++;
                if (load3) loads++;
                if (en3)   ens++;
                if (k == 1) begin
                    check("load_cycle1", load3, 1);
                    check("period_cleared", per3, 0);
                    check("seed_captured", lseed3, vecs[i].seed);
                end
                if (done3) got = 1'b1;
            end
            check("done_cycle", k, vecs[i].done_cyc);
            check("load_cycles", loads, 1);
            check("enable_cycles", ens, vecs[i].en_cycles);
            check("period", per3, vecs[i].period);
            check("maximal", max3, vecs[i].maximal);
            check("stuck", stk3, vecs[i].stuck);
            check("timeout", to3, vecs[i].timeout);
            check("ones_count", ones3, c_bal * vecs[i].ones);
            @(negedge clk);
            check("done_pulse", done3, 0);
            check("idle_busy", busy3, 0);
            check("period_held", per3, vecs[i].period);
        end
        runaway = 1'b0;

        // WIDTH=9: start during RUN must be ignored.
        start9 = 1'b1;
        seed9  = 9'h001;
        @(posedge clk);
        #1 start9 = 1'b0;
        k = 0; got = 1'b0;
        while (k < 600 && !got) begin
            @(negedge clk);
            k++;
            if (k == 5) begin
                start9 = 1'b1;
                seed9  = 9'h0AA;
            end else begin
                start9 = 1'b0;
            end
            if (done9) got = 1'b1;
        end
        check("w9_done_cycle", k, 515);
        check("w9_seed_kept", lseed9, 9'h001);
        check("w9_period", per9, 511);
        check("w9_maximal", max9, 1);
        check("w9_timeout", to9, 0);
        check("w9_ones", ones9, c_bal * 256);
        @(negedge clk);

        // WIDTH=4: reset in cycle 6 of a run aborts to IDLE.
        start4 = 1'b1;
        seed4  = 4'h1;
        @(posedge clk);
        #1 start4 = 1'b0;
        for (int c = 1; c <= 6; c++) @(negedge clk);
        check("w4_running", en4, 1);
        rst = 1'b1;
        @(negedge clk);
        check("w4_rst_busy", busy4, 0);
        check("w4_rst_ctrl", {load4, en4, done4}, 0);
        check("w4_rst_seed", lseed4, 0);
        check("w4_rst_period", per4, 0);
        check("w4_rst_flags", {max4, stk4, to4}, 0);
        check("w4_rst_ones", ones4, 0);
        rst    = 1'b0;
        start4 = 1'b1;
        seed4  = 4'h8;
        @(posedge clk);
        #1 start4 = 1'b0;
        k = 0; got = 1'b0;
        while (k < 60 && !got) begin
            @(negedge clk);
            k++;
            if (done4) got = 1'b1;
        end
        check("w4_done_cycle", k, 19);
        check("w4_period", per4, 15);
        check("w4_maximal", max4, 1);
        check("w4_stuck", stk4, 0);
        check("w4_ones", ones4, c_bal * 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_period_checker.md
Name: lfsr_period_checker

Overview:
- Downstream consumer and controller for one LFSR instance (ports In, clock, load, enable, Out).
- Loads a seed into the LFSR, then steps it until the seed state reappears, and reports the measured period.
- Flags maximal-length sequences, all-zero lock-up, and runaway sequences that never return to the seed.
- Used in BIST and bring-up to qualify each LFSR width (3..9) without a bench-side reference model.

Parameters:
WIDTH, 9, LFSR state width; must match the attached LFSR; legal range 3..16.

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  request a measurement; accepted only in IDLE
seed  in  WIDTH  seed value, captured when start is accepted
lfsr_out  in  WIDTH  LFSR Out
lfsr_seed  out  WIDTH  drives LFSR In; holds the captured seed
lfsr_load  out  1  drives LFSR load
lfsr_enable  out  1  drives LFSR enable
busy  out  1  high in LOAD, PRIME and RUN
done  out  1  one-cycle pulse when results become valid
period  out  WIDTH+1  measured period in LFSR steps
maximal  out  1  period == 2^WIDTH-1
stuck  out  1  all-zero state observed
timeout  out  1  no return to seed within 2^WIDTH steps
ones_count  out  WIDTH  see Optional Feature

Behaviour:
- Reset: state=IDLE. Every output is 0, including lfsr_seed, period, the flags and ones_count. The internal count and reference register are cleared.
- FSM states: IDLE, LOAD, PRIME, RUN, DONE. Outputs are Moore-style, decoded from state.
- IDLE:
  - If start=1: capture seed into lfsr_seed, clear period/maximal/stuck/timeout/ones_count, and go to LOAD.
  - Otherwise stay in IDLE. Results from the previous run stay held.
- LOAD: lfsr_load=1, lfsr_enable=0. The LFSR takes the seed on this edge. Next state is PRIME.
- PRIME: load=0, enable=0, and lfsr_out now equals the seed.
  - Register ref<=lfsr_out and count<=0.
  - If lfsr_out==0: set stuck=1, period=0, go to DONE.
  - Else go to RUN.
- RUN: lfsr_enable=1, so the LFSR advances every cycle. Conditions are evaluated each cycle in priority order:
  - count!=0 and lfsr_out==ref: period<=count, maximal<=(count==2^WIDTH-1), go to DONE.
  - lfsr_out==0: stuck<=1, period<=count, go to DONE.
  - count==2^WIDTH: timeout<=1, period<=count, go to DONE.
  - Otherwise count<=count+1 and stay in RUN.
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
  - The LFSR ends one step past the seed; this is accepted behaviour.
- Latency: done is asserted N+4 cycles after the cycle in which start is accepted (N = period). For stuck-in-PRIME, done is asserted 3 cycles after.
- count is WIDTH+1 bits wide and never wraps, because the timeout check caps it at 2^WIDTH.
- start is ignored while busy or in DONE. There is no queueing.
- Results (period and flags) hold until the next accepted start.
- Reset mid-operation aborts immediately to IDLE with all outputs zeroed. lfsr_load and lfsr_enable drop on the reset edge.

Optional Feature:
- Macro: LFSR_CHK_BALANCE_EN.
- When defined: ones_count increments in each RUN cycle where lfsr_out[0]==1 and the cycle does not terminate the run. This covers exactly the states seed..last before return. For a maximal run the result is 2^(WIDTH-1), which saturates at 2^WIDTH-1.
- When undefined: the counter logic is absent and ones_count is tied to 0. The port list is unchanged.

Test Plan:
- Normal run (WIDTH=3, maximal LFSR): seed=3'b001, start pulse in cycle 0 -> lfsr_load high in cycle 1 only; lfsr_enable high cycles 3-10; done in cycle 11; period=7, maximal=1, stuck=0, timeout=0; with LFSR_CHK_BALANCE_EN, ones_count=4.
- All-zero seed (WIDTH=3): seed=0 -> done in cycle 3, stuck=1, period=0, maximal=0, lfsr_enable never asserted.
- Runaway sequence (WIDTH=3): the bench replaces the LFSR with a model emitting 1,2,3,4,5,4,5,... -> timeout=1, period=8, maximal=0, done in cycle 12.
- Start while busy: after a WIDTH=9 run starts with seed=9'h001, pulse start with seed=9'h0AA in cycle 5 -> ignored; lfsr_seed stays 9'h001; period=511, maximal=1.
- Reset mid-RUN: assert reset in cycle 6 of a WIDTH=4 run -> in cycle 7 all outputs are 0 and state=IDLE; a new start with seed=4'h8 then completes with period=15, maximal=1.
- Back-to-back runs: start with seed=3'b001, then seed=3'b110 immediately after done -> both runs report period=7; results from the first run hold until the second start is accepted.
